phase_sequencer: RTL and testbench

//  Parametrised phase-selection controller for the PLL output stage.
//  On trigger, scans a mask of N_PHASES enabled phases and drives the first enabled index.

---
 rtl/phase_sequencer.sv | 175 +++++++++++++++++
 tb/tb_phase_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/phase_sequencer.sv
// Phase-selection controller for the PLL output-stage phase-shift mux.
// Scans an enable mask for the next selectable phase, manually or on a dwell timer.
module phase_sequencer #(
   parameter int N_PHASES       = 32,
   parameter int HOLDOFF_CYCLES = 500000,
   parameter int DWELL_W        = 32
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        armed,
   input  logic                        trigger,
   input  logic                        change_phase,
   input  logic                        abort,
   input  logic [N_PHASES-1:0]         active_mask,
   input  logic                        auto_mode,
   input  logic                        wrap_en,
   input  logic [DWELL_W-1:0]          dwell_cycles,
   output logic [$clog2(N_PHASES)-1:0] phase_out,
   output logic                        output_on,
   output logic [1:0]                  state_out,
   output logic                        phase_step,
   output logic                        seq_done
);

   // state   | meaning
   // HOLDOFF | output off, wait HOLDOFF_CYCLES before accepting a trigger
   // IDLE    | output off, waiting for trigger && armed
   // SEARCH  | testing one mask index per cycle for the next enabled phase
   // ON      | phase driven; advance on change_phase edge or dwell expiry

   localparam int PW = $clog2(N_PHASES);
   localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
   localparam logic [PW-1:0]      LAST_IDX  = PW'(N_PHASES - 1);
   localparam logic [HW-1:0]      HOLD_LAST = HW'(HOLDOFF_CYCLES - 1);
   localparam logic [DWELL_W-1:0] DWELL_MAX = '1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_SEARCH  = 2'b01,
      ST_ON      = 2'b10,
      ST_HOLDOFF = 2'b11
   } state_t;

   state_t             state, state_n;
   logic [HW-1:0]      hold_cnt, hold_cnt_n;
   logic [DWELL_W-1:0] dwell_cnt, dwell_cnt_n;
   logic [PW-1:0]      scan, scan_n;
   logic [PW-1:0]      idx, idx_n;
   logic [PW-1:0]      phase_out_n;
   logic               output_on_n;
   logic               phase_step_n;
   logic               seq_done_n;
   logic               change_phase_q;

   logic          cp_edge;
   logic          dwell_hit;
   logic          stop;
   logic [PW-1:0] idx_adv;

   assign cp_edge   = change_phase && !change_phase_q;
   assign dwell_hit = auto_mode && (dwell_cycles != '0)
                      && (dwell_cnt == dwell_cycles - DWELL_W'(1));
   assign stop      = abort || !armed;
   assign idx_adv   = (idx == LAST_IDX) ? '0 : idx + PW'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= ST_HOLDOFF;
         hold_cnt       <= '0;
         dwell_cnt      <= '0;
         scan           <= '0;
         idx            <= '0;
         phase_out      <= '0;
         output_on      <= 1'b0;
         phase_step     <= 1'b0;
         seq_done       <= 1'b0;
         change_phase_q <= 1'b0;
      end else begin
         state          <= state_n;
         hold_cnt       <= hold_cnt_n;
         dwell_cnt      <= dwell_cnt_n;
         scan           <= scan_n;
         idx            <= idx_n;
         phase_out      <= phase_out_n;
         output_on      <= output_on_n;
         phase_step     <= phase_step_n;
         seq_done       <= seq_done_n;
         change_phase_q <= change_phase;
      end
   end

   always_comb begin
      state_n      = state;
      hold_cnt_n   = hold_cnt;
      dwell_cnt_n  = dwell_cnt;
      scan_n       = scan;
      idx_n        = idx;
      phase_out_n  = phase_out;
      output_on_n  = output_on;
      phase_step_n = 1'b0;
      seq_done_n   = 1'b0;

      case (state)
         ST_HOLDOFF: begin
            output_on_n = 1'b0;
            if (hold_cnt == HOLD_LAST) begin
               state_n    = ST_IDLE;
               hold_cnt_n = '0;
            end else begin
               hold_cnt_n = hold_cnt + HW'(1);
            end
         end

         ST_IDLE: begin
            idx_n       = '0;
            scan_n      = '0;
            output_on_n = 1'b0;
            if (trigger && armed) state_n = ST_SEARCH;
         end

         ST_SEARCH: begin
            if (stop) begin
               state_n     = ST_HOLDOFF;
               hold_cnt_n  = '0;
               output_on_n = 1'b0;
            end else if (active_mask[idx]) begin
               state_n      = ST_ON;
               phase_out_n  = idx;
               output_on_n  = 1'b1;
               phase_step_n = 1'b1;
               dwell_cnt_n  = '0;
            end else if ((scan == LAST_IDX) || ((idx == LAST_IDX) && !wrap_en)) begin
               state_n     = ST_HOLDOFF;
               hold_cnt_n  = '0;
               output_on_n = 1'b0;
               seq_done_n  = 1'b1;
            end else begin
               idx_n  = idx_adv;
               scan_n = scan + PW'(1);
            end
         end

         ST_ON: begin
            if (stop) begin
               state_n     = ST_HOLDOFF;
               hold_cnt_n  = '0;
               output_on_n = 1'b0;
            end else begin
               // saturate so a long manual dwell never wraps into a false expiry
               if (dwell_cnt != DWELL_MAX) dwell_cnt_n = dwell_cnt + DWELL_W'(1);
               if (cp_edge || dwell_hit) begin
                  if ((idx == LAST_IDX) && !wrap_en) begin
                     state_n     = ST_HOLDOFF;
                     hold_cnt_n  = '0;
                     output_on_n = 1'b0;
                     seq_done_n  = 1'b1;
                  end else begin
                     state_n = ST_SEARCH;
                     idx_n   = idx_adv;
                     scan_n  = '0;
                  end
               end
            end
         end

         default: begin
            state_n    = ST_HOLDOFF;
            hold_cnt_n = '0;
         end
      endcase
   end

   assign state_out = state;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: expected step/done events go into a queue,
// a monitor pops and compares them whenever the DUT pulses phase_step or seq_done.
module tb_phase_sequencer;

   localparam int N  = 8;
   localparam int HC = 4;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          armed;
   logic          trigger;
   logic          change_phase;
   logic          abort;
   logic [N-1:0]  active_mask;
   logic          auto_mode;
   logic          wrap_en;
   logic [DW-1:0] dwell_cycles;
   logic [2:0]    phase_out;
   logic          output_on;
   logic [1:0]    state_out;
   logic          phase_step;
   logic          seq_done;

   int checks = 0;
   int errors = 0;
   int n;
   logic [4:0] exp_q[$];

   phase_sequencer #(
      .N_PHASES(N),
      .HOLDOFF_CYCLES(HC),
      .DWELL_W(DW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .armed(armed),
      .trigger(trigger),
      .change_phase(change_phase),
      .abort(abort),
      .active_mask(active_mask),
      .auto_mode(auto_mode),
      .wrap_en(wrap_en),
      .dwell_cycles(dwell_cycles),
      .phase_out(phase_out),
      .output_on(output_on),
      .state_out(state_out),
      .phase_step(phase_step),
      .seq_done(seq_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Advance until a step/done pulse; single-cycle inputs are dropped after the first edge.
   task automatic wait_event(output int cnt, input int budget);
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
         trigger      = 1'b0;
         change_phase = 1'b0;
      end while (!(phase_step || seq_done) && cnt < budget);
      if (!(phase_step || seq_done)) begin
         checks++;
         errors++;
         $display("FAIL event_timeout actual=none required=pulse within %0d", budget);
      end
   endtask

   task automatic wait_state(input logic [1:0] s, input int budget);
      int cnt;
      cnt = 0;
      while (state_out !== s && cnt < budget) begin
         @(negedge clk);
         cnt++;
      end
      if (state_out !== s) begin
         checks++;
         errors++;
         $display("FAIL state_timeout actual=%0d required=%0d", state_out, s);
      end
   endtask

   // Monitor: kind 01 = phase_step, 10 = seq_done; phase is phase_out at the pulse.
   initial begin
      logic [4:0] e;
      forever begin
         @(negedge clk);
         if (phase_step || seq_done) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_event actual=%b required=none", {seq_done, phase_step});
            end else begin
               e = exp_q.pop_front();
               check("event_kind", {30'd0, seq_done, phase_step}, {30'd0, e[4:3]});
               check("event_phase", {29'd0, phase_out}, {29'd0, e[2:0]});
            end
         end
      end
   end

   initial begin
      rst          = 1'b1;
      armed        = 1'b0;
      trigger      = 1'b0;
      change_phase = 1'b0;
      abort        = 1'b0;
      active_mask  = '0;
      auto_mode    = 1'b0;
      wrap_en      = 1'b0;
      dwell_cycles = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 5; i++) begin
         check("holdoff_state", state_out, (i < 4) ? 3 : 0);
         check("holdoff_output_on", output_on, 0);
         if (i == 0) check("reset_phase", phase_out, 0);
         if (i < 4) @(negedge clk);
      end

      // first enabled phase 2, manual advance to 5, then run off the end without wrap
      active_mask = 8'b0010_0100;
      armed       = 1'b1;
      exp_q.push_back({2'b01, 3'd2});
      trigger = 1'b1;
      wait_event(n, 20);
      check("trigger_latency", n, 4);
      check("trigger_output_on", output_on, 1);
      repeat (3) @(negedge clk);
      exp_q.push_back({2'b01, 3'd5});
      change_phase = 1'b1;
      wait_event(n, 20);
      check("advance_latency", n, 4);
      repeat (3) @(negedge clk);
      exp_q.push_back({2'b10, 3'd5});
      change_phase = 1'b1;
      wait_event(n, 20);
      check("nowrap_done_latency", n, 3);
      check("nowrap_done_state", state_out, 3);
      check("nowrap_done_output_on", output_on, 0);
      wait_state(2'b00, 10);

      // single enabled phase with wrap: advance comes back to 0 after 8 scan cycles
      wrap_en     = 1'b1;
      active_mask = 8'b0000_0001;
      exp_q.push_back({2'b01, 3'd0});
      trigger = 1'b1;
      wait_event(n, 20);
      check("mask0_latency", n, 2);
      repeat (2) @(negedge clk);
      exp_q.push_back({2'b01, 3'd0});
      change_phase = 1'b1;
      wait_event(n, 30);
      check("wrap_latency", n, 9);
      check("wrap_output_on", output_on, 1);
      abort = 1'b1;
      @(negedge clk);
      check("abort_on_state", state_out, 3);
      check("abort_on_output_on", output_on, 0);
      abort = 1'b0;
      wait_state(2'b00, 10);

      // auto mode: each phase 3 ON cycles + 1 SEARCH cycle
      active_mask  = 8'hFF;
      auto_mode    = 1'b1;
      dwell_cycles = 8'd3;
      for (int s = 0; s < 5; s++) exp_q.push_back({2'b01, 3'(s)});
      trigger = 1'b1;
      for (int s = 0; s < 5; s++) begin
         wait_event(n, 30);
         check("auto_gap", n, (s == 0) ? 2 : 4);
      end
      repeat (3) @(negedge clk);
      check("auto_search_state", state_out, 1);
      check("search_holds_output_on", output_on, 1);
      check("search_holds_phase", phase_out, 4);
      armed = 1'b0;
      @(negedge clk);
      check("disarm_search_state", state_out, 3);
      check("disarm_output_on", output_on, 0);
      armed     = 1'b1;
      auto_mode = 1'b0;
      wait_state(2'b00, 10);

      // empty mask: abort mid-search, then a full search that ends in seq_done
      active_mask = '0;
      trigger     = 1'b1;
      @(negedge clk);
      trigger = 1'b0;
      repeat (2) @(negedge clk);
      check("empty_search_state", state_out, 1);
      abort = 1'b1;
      @(negedge clk);
      check("abort_search_state", state_out, 3);
      check("abort_phase_holds", phase_out, 4);
      abort = 1'b0;
      wait_state(2'b00, 10);
      wrap_en = 1'b0;
      exp_q.push_back({2'b10, 3'd4});
      trigger = 1'b1;
      wait_event(n, 20);
      check("empty_done_latency", n, 9);
      check("empty_done_state", state_out, 3);
      check("empty_done_output_on", output_on, 0);

      repeat (4) @(negedge clk);
      check("queue_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
